// File: rtl/fractal_axis_packer_if.sv
// fractal_axis_packer_if: AXI4-Stream beat bus between the packer (master) and the video DMA (slave)
interface fractal_axis_packer_if #(
  parameter int DW = 48,
  parameter int KW = 6
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  modport master(output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/fractal_axis_packer.sv
// fractal_axis_packer: packs a non-stallable pixel stream into FIFO-buffered AXI4-Stream beats, dropping to the next frame start on overflow; FRACTAL_PACKER_STATS_EN adds frame/drop counters
module fractal_axis_packer #(
  parameter int PIXEL_WIDTH     = 24,
  parameter int PIXELS_PER_BEAT = 2,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [PIXEL_WIDTH-1:0]       data_in,
  input  logic                         frame_start_in,
  input  logic                         line_end_in,
  input  logic                         data_enable_in,
  fractal_axis_packer_if.master        m_axis,
  input  logic                         clear_overflow,
  output logic                         overflow,
  output logic [15:0]                  frames_out,
  output logic [31:0]                  pixels_dropped
);
  localparam int DW = PIXEL_WIDTH * PIXELS_PER_BEAT;
  localparam int KW = DW / 8;
  localparam int BW = DW + KW + 2;
  localparam int IW = $clog2(PIXELS_PER_BEAT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = AW + 2;
  localparam logic [XW-1:0] DEPTH_X   = XW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_SLOT = IW'(PIXELS_PER_BEAT - 1);
  typedef enum logic {PACK, DROP} state_t;
  function automatic logic [KW-1:0] keep_of(input logic [IW-1:0] n);
    keep_of = '0;
    for (int i = 0; i < KW; i++) keep_of[i] = (i * 8) < (int'(n) * PIXEL_WIDTH);
  endfunction
  state_t          r_state, w_next;
  logic [DW-1:0]   r_pack, w_data;
  logic [IW-1:0]   r_idx, w_slot;
  logic            r_user, w_user, w_take, w_flush, w_done, w_ovf, w_rd, w_load, r_ovalid, r_ovf;
  logic [BW-1:0]   r_mem [FIFO_DEPTH];
  logic [BW-1:0]   r_out, w_beat_f, w_beat_c;
  logic [AW-1:0]   r_wp, r_rp;
  logic [XW-1:0]   r_mcnt, w_nwr, w_room, w_acc;
  // state register
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_state <= PACK;
    else r_state <= w_next;
  // next state: an overflowing beat enters DROP, a frame start resynchronises
  always_comb w_next = w_ovf ? DROP : (data_enable_in & frame_start_in) ? PACK : r_state;
  // state output: which incoming pixels get packed
  always_comb w_take = data_enable_in & ((r_state == PACK) | frame_start_in);
  // beat assembly: a frame start restarts at slot 0 and flushes any partial beat with tlast
  always_comb begin
    w_slot   = frame_start_in ? '0 : r_idx;
    w_data   = (frame_start_in ? '0 : r_pack) | (DW'(data_in) << (int'(w_slot) * PIXEL_WIDTH));
    w_user   = frame_start_in | r_user;
    w_flush  = w_take & frame_start_in & (r_idx != '0);
    w_done   = w_take & ((w_slot == LAST_SLOT) | line_end_in);
    w_beat_f = {r_pack, keep_of(r_idx), r_user, 1'b1};
    w_beat_c = {w_data, keep_of(w_slot + IW'(1)), w_user, line_end_in};
  end
  // admission: occupancy includes the output register, and a same-cycle sink pop frees a slot
  always_comb begin
    w_rd   = r_ovalid & m_axis.tready;
    w_load = (r_mcnt != '0) & (~r_ovalid | m_axis.tready);
    w_nwr  = XW'(w_flush) + XW'(w_done);
    w_room = DEPTH_X - r_mcnt - XW'(r_ovalid) + XW'(w_rd);
    w_acc  = (w_nwr <= w_room) ? w_nwr : w_room;
    w_ovf  = w_acc != w_nwr;
  end
  // pack register, emptied whenever its beat leaves (written or dropped)
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_pack <= '0;
      r_idx  <= '0;
      r_user <= 1'b0;
    end else if (w_ovf | w_done) begin
      r_pack <= '0;
      r_idx  <= '0;
      r_user <= 1'b0;
    end else if (w_take) begin
      r_pack <= w_data;
      r_idx  <= w_slot + IW'(1);
      r_user <= w_user;
    end
  // beat storage; a flush and a completed single-pixel beat can land in the same cycle
  always_ff @(posedge aclk) begin
    if (w_acc != '0) r_mem[r_wp] <= w_flush ? w_beat_f : w_beat_c;
    if (w_acc == XW'(2)) r_mem[r_wp + AW'(1)] <= w_beat_c;
  end
  // pointers, count and the first-word-fall-through output register
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_mcnt   <= '0;
      r_out    <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_wp   <= r_wp + AW'(w_acc);
      r_mcnt <= r_mcnt + w_acc - XW'(w_load);
      if (w_load) begin
        r_out    <= r_mem[r_rp];
        r_rp     <= r_rp + AW'(1);
        r_ovalid <= 1'b1;
      end else if (w_rd) r_ovalid <= 1'b0;
    end
  // sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_ovf <= 1'b0;
    else r_ovf <= w_ovf | (r_ovf & ~clear_overflow);
  assign m_axis.tdata  = r_out[BW-1 -: DW];
  assign m_axis.tkeep  = r_out[KW+1:2];
  assign m_axis.tuser  = r_out[1];
  assign m_axis.tlast  = r_out[0];
  assign m_axis.tvalid = r_ovalid;
  assign overflow      = r_ovf;
`ifdef FRACTAL_PACKER_STATS_EN
  logic [15:0] r_frames;
  logic [31:0] r_dropped, w_drop_pix;
  logic [32:0] w_drop_sum;
  // pixels lost this cycle: one discarded in DROP, or every pixel of the overflowing beat(s)
  always_comb begin
    w_drop_pix = (data_enable_in & ~w_take) ? 32'd1 :
                 w_ovf ? (((w_flush & (w_acc == '0)) ? 32'(r_idx) : 32'd0) + 32'(w_slot) + 32'd1) : 32'd0;
    w_drop_sum = {1'b0, r_dropped} + {1'b0, w_drop_pix};
  end
  // frame counter wraps, drop counter saturates; both clear with overflow
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_frames  <= '0;
      r_dropped <= '0;
    end else if (clear_overflow) begin
      r_frames  <= '0;
      r_dropped <= '0;
    end else begin
      if (w_rd & r_out[1]) r_frames <= r_frames + 16'd1;
      r_dropped <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
    end
  assign frames_out     = r_frames;
  assign pixels_dropped = r_dropped;
`else
  assign frames_out     = '0;
  assign pixels_dropped = '0;
`endif
endmodule

// File: tb/tb_fractal_axis_packer.sv
// tb_fractal_axis_packer: randomized scoreboard bench with a queue-based pixel packing reference model
module tb_fractal_axis_packer;
  localparam int PW    = 24;
  localparam int PPB   = 2;
  localparam int DEPTH = 64;
  localparam int DW    = PW * PPB;
  localparam int KW    = DW / 8;
  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic u; logic l;} beat_t;
  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [PW-1:0] data_in = '0;
  logic          frame_start_in = 1'b0, line_end_in = 1'b0, data_enable_in = 1'b0, clear_overflow = 1'b0;
  logic          overflow;
  logic [15:0]   frames_out;
  logic [31:0]   pixels_dropped;
  logic          ready_mode = 1'b0, ready_force = 1'b0;
  fractal_axis_packer_if #(.DW(DW), .KW(KW)) axis ();
  fractal_axis_packer #(.PIXEL_WIDTH(PW), .PIXELS_PER_BEAT(PPB), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .data_in(data_in), .frame_start_in(frame_start_in),
    .line_end_in(line_end_in), .data_enable_in(data_enable_in), .m_axis(axis),
    .clear_overflow(clear_overflow), .overflow(overflow), .frames_out(frames_out),
    .pixels_dropped(pixels_dropped));
  always #5 aclk = ~aclk;
  int errors = 0, checks = 0;
  beat_t sb[$];
  logic [PW-1:0] m_pix[$];
  bit m_user, m_drop, m_ovf;
  int m_dropped, m_frames;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic chk_stats(input string name);
`ifdef FRACTAL_PACKER_STATS_EN
    chk({name, "_frames_out"}, 64'(frames_out), 64'(m_frames));
    chk({name, "_pixels_dropped"}, 64'(pixels_dropped), 64'(m_dropped));
`else
    chk({name, "_frames_out"}, 64'(frames_out), 64'd0);
    chk({name, "_pixels_dropped"}, 64'(pixels_dropped), 64'd0);
`endif
  endtask
  // close the collected pixels into one expected beat, or drop it if the buffer is full
  function automatic void emit(input bit last);
    beat_t b;
    b = '0;
    foreach (m_pix[i]) b.d |= DW'(m_pix[i]) << (i * PW);
    b.k = KW'((64'd1 << (m_pix.size() * PW / 8)) - 64'd1);
    b.u = m_user;
    b.l = last;
    if (sb.size() >= DEPTH) begin
      m_drop = 1;
      m_ovf = 1;
      m_dropped += m_pix.size();
    end else sb.push_back(b);
    m_pix.delete();
    m_user = 0;
  endfunction
  function automatic void model_pix(input logic [PW-1:0] d, input bit fs, input bit le);
    if (m_drop && !fs) begin
      m_dropped++;
      return;
    end
    m_drop = 0;
    if (fs && m_pix.size() != 0) emit(1'b1);
    if (m_drop) begin
      m_dropped++;
      return;
    end
    m_pix.push_back(d);
    m_user |= fs;
    if (le || m_pix.size() == PPB) emit(le);
  endfunction
  task automatic model_reset();
    sb.delete();
    m_pix.delete();
    m_user = 0;
    m_drop = 0;
    m_ovf = 0;
    m_dropped = 0;
    m_frames = 0;
  endtask
  task automatic px(input logic [PW-1:0] d, input bit fs, input bit le);
    data_in = d;
    frame_start_in = fs;
    line_end_in = le;
    data_enable_in = 1'b1;
    model_pix(d, fs, le);
    @(posedge aclk);
    #1;
    data_enable_in = 1'b0;
    frame_start_in = 1'b0;
    line_end_in = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask
  task automatic drain(input string name);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 2000) begin
      @(posedge aclk);
      #1;
      i++;
    end
    chk({name, "_drained"}, 64'(sb.size()), 64'd0);
  endtask
  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      axis.tready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end
  beat_t got, prev, exp_b;
  bit stall_prev = 0;
  always @(negedge aclk) begin
    got = {axis.tdata, axis.tkeep, axis.tuser, axis.tlast};
    if (areset) stall_prev = 0;
    else begin
      if (stall_prev) chk("stall_hold", 64'(got), 64'(prev));
      if (axis.tvalid && axis.tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, want none", got);
        end else begin
          exp_b = sb.pop_front();
          chk("beat", 64'(got), 64'(exp_b));
          if (exp_b.u) m_frames++;
        end
      end
      stall_prev = axis.tvalid && !axis.tready;
      prev = got;
    end
  end
  initial begin
    model_reset();
    idle(3);
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_tkeep", 64'(axis.tkeep), 64'd0);
    chk("rst_tdata", 64'(axis.tdata), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk_stats("rst");
    areset = 1'b0;
    ready_force = 1'b1;
    idle(2);
    px(24'hA0A0A1, 1, 0);
    px(24'hB0B0B2, 0, 0);
    chk("tvalid_1cyc_after_b", 64'(axis.tvalid), 64'd0);
    px(24'hC0C0C3, 0, 0);
    chk("tvalid_2cyc_after_b", 64'(axis.tvalid), 64'd1);
    px(24'hD0D0D4, 0, 1);
    drain("line4");
    px(24'h000111, 1, 0);
    px(24'h000222, 0, 0);
    px(24'h000333, 0, 1);
    drain("line3");
    for (int i = 0; i < 20; i++) begin
      if (i == 4) ready_force = 1'b0;
      if (i == 14) ready_force = 1'b1;
      px(PW'(32'h100 + i), i == 0, i == 19);
    end
    drain("stall10");
    chk("stall10_overflow", 64'(overflow), 64'd0);
    px(24'h123456, 1, 1);
    drain("single_pixel");
    ready_mode = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int lines;
      lines = $urandom_range(1, 3);
      for (int l = 0; l < lines; l++) begin
        int len;
        bit trunc;
        len = $urandom_range(1, 7);
        trunc = (l == lines - 1) && ($urandom_range(0, 2) == 0);
        for (int p = 0; p < len; p++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          px(PW'($urandom), (l == 0) && (p == 0), (p == len - 1) && !trunc);
        end
      end
    end
    px(PW'($urandom), 1, 1);
    ready_mode = 1'b0;
    ready_force = 1'b1;
    drain("random");
    chk("random_overflow", 64'(overflow), 64'(m_ovf));
    chk_stats("random");
    ready_force = 1'b0;
    idle(3);
    for (int i = 0; i < 140; i++) px(PW'(1000 + i), i == 0, (i % 20) == 19);
    chk("ovf_set", 64'(overflow), 64'(m_ovf));
    for (int i = 0; i < 6; i++) px(PW'(2000 + i), 0, i == 5);
    ready_force = 1'b1;
    drain("ovf");
    chk_stats("ovf");
    px(24'h00AA01, 1, 0);
    px(24'h00AA02, 0, 1);
    drain("resync");
    chk("resync_overflow", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    @(posedge aclk);
    #1;
    clear_overflow = 1'b0;
    m_ovf = 0;
    m_dropped = 0;
    m_frames = 0;
    chk("clear_overflow", 64'(overflow), 64'd0);
    chk_stats("clear");
    ready_force = 1'b0;
    idle(2);
    for (int i = 0; i < 6; i++) px(PW'(50 + i), i == 0, i == 5);
    idle(3);
    chk("queued_tvalid", 64'(axis.tvalid), 64'd1);
    #2;
    areset = 1'b1;
    #1;
    chk("async_rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("async_rst_tkeep", 64'(axis.tkeep), 64'd0);
    model_reset();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    ready_force = 1'b1;
    idle(2);
    px(24'h000007, 0, 0);
    px(24'h000008, 0, 1);
    px(24'h000009, 1, 0);
    px(24'h00000A, 0, 1);
    drain("post_reset");
    chk_stats("final");
    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
